equiv_sweep_ctrl: RTL and testbench
===================================

# equiv_sweep_ctrl

Sequencer that exhaustively sweeps the 3-input vector {z,y,x} through 0..7 and drives it into two boolean-law implementations under comparison. It holds each vector for a programmable settle time, then compares their single-bit results `s_a` and `s_b`, and accumulates a mismatch report. It sits between a start/done control interface and the pair of combinational law modules (e.g. associative/commutative variants), replacing a free-running testbench stimulus with a synthesizable, clocked checker.

## Interface
- `HOLD_CYCLES`, default 4: cycles each vector is held before comparison; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  begin a sweep; sampled only in IDLE.
- `s_a`  input  1  result of law implementation A for current {z,y,x}.
- `s_b`  input  1  result of law implementation B for current {z,y,x}.
- `x`, `y`, `z`  output  1 each  registered stimulus bits; vector index = {z,y,x}, x is LSB.
- `busy`  output  1  high in HOLD and CHECK.
- `done`  output  1  one-cycle pulse at sweep end.
- `pass`  output  1  1 when last completed sweep had zero mismatches; held until next start.
- `fail_cnt`  output  4  mismatch count of current/last sweep, 0..8.
- `fail_seen`  output  1  at least one mismatch in current/last sweep.
- `first_fail`  output  3  vector index of first mismatch; 0 when none.

## Operation
- States: IDLE, HOLD, CHECK, DONE. Reset state IDLE.
- IDLE: `start`=1 → HOLD. Same edge: vec←0, hold counter←0, `fail_cnt`←0, `fail_seen`←0, `first_fail`←0, `pass`←0.
- HOLD: counter increments each cycle. When counter = HOLD_CYCLES−1 → CHECK.
- CHECK: compare `s_a` vs `s_b` combinationally against registered x/y/z.
  - On mismatch: `fail_cnt`+1. If `fail_seen`=0, `first_fail`←vec and `fail_seen`←1.
  - If vec=7 → DONE; else vec+1, counter←0 → HOLD.
- DONE: `done`=1 for this cycle only. `pass`←(final mismatch count = 0), using the CHECK-updated count. Then → IDLE.
- x/y/z hold their last value in IDLE/DONE: 7 after a full sweep, the failing vector after an early stop.
- `fail_cnt` saturates at 8 by construction; width 4, no wrap.
- `start` outside IDLE is ignored. `start` held high continuously restarts a sweep on the cycle after DONE.
- Reset at any time: state IDLE and all outputs 0 on assertion, regardless of clock. Sweep in progress is abandoned.
- Reset values: x=y=z=0, `busy`=0, `done`=0, `pass`=0, `fail_cnt`=0, `fail_seen`=0, `first_fail`=0.

## Timing
- Edge sampling `start` = edge 0. x/y/z=0 and `busy`=1 are visible after edge 0.
- Each vector occupies HOLD_CYCLES+1 cycles: HOLD_CYCLES cycles in HOLD, then 1 in CHECK.
- Full sweep: DONE entered at edge 8·(HOLD_CYCLES+1); with default 4, `done` is high during cycle 40–41, i.e. 41 cycles after start.
- `busy` falls on entry to DONE. `done` and `busy` are never high together.
- `s_a`/`s_b` must settle within HOLD_CYCLES cycles of x/y/z changing. The block does not register them before CHECK.

## Configuration
- `EQUIV_STOP_ON_FAIL_EN` defined: CHECK with a mismatch goes directly to DONE.
  - `fail_cnt`=1, `first_fail` and x/y/z hold the failing vector, `pass`=0.
- Not defined: always a full 8-vector sweep; all mismatches are counted.

## Test plan
- `s_a`=`s_b`=(x&y)|z (identical implementations), HOLD_CYCLES=4, pulse `start` → `done` 41 cycles later, `pass`=1, `fail_cnt`=0, `fail_seen`=0, x/y/z=1/1/1.
- `s_b` inverted only when {z,y,x}=5 → `fail_cnt`=1, `first_fail`=5, `pass`=0.
- `s_a`=x, `s_b`=0, macro undefined → `fail_cnt`=4, `first_fail`=1. Macro defined → `done` after 2·5+1=11 cycles, `fail_cnt`=1, `first_fail`=1, {z,y,x}=1.
- Assert `rst` asynchronously mid-HOLD at vec 3 → outputs 0 immediately, state IDLE. After release, `start` runs a complete sweep with correct results.
- Pulse `start` while `busy` → ignored, `done` timing unchanged. Hold `start` high → second sweep begins the cycle after `done`, counters cleared.
- HOLD_CYCLES=1 with identical inputs → `done` at cycle 17, `pass`=1.

Source files
------------

// File: rtl/equiv_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// equiv_sweep_ctrl
//
// Clocked equivalence checker for two single-bit combinational law
// implementations. On start it walks the stimulus vector {z,y,x} through
// 0..7. Each vector is held for HOLD_CYCLES cycles so that both
// implementations can settle. It then compares s_a_i against s_b_i and
// accumulates a mismatch report.
//
// Optional feature macro: EQUIV_STOP_ON_FAIL_EN
//   When this macro is defined, the first mismatch ends the sweep at once.
//   The failing vector stays on x/y/z and in first_fail_o.
//   When it is undefined, all eight vectors are always checked and every
//   mismatch is counted.
//
// Parameters
//   HOLD_CYCLES   cycles each vector is held before its check (legal 1..15)
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous, active-high reset
//   start_i       begin a sweep; sampled only while idle
//   s_a_i         result of implementation A for the current {z,y,x}
//   s_b_i         result of implementation B for the current {z,y,x}
//   x_o/y_o/z_o   registered stimulus bits, vector index = {z,y,x}
//   busy_o        high while holding or checking a vector
//   done_o        one-cycle pulse at the end of a sweep
//   pass_o        last completed sweep had zero mismatches
//   fail_cnt_o    mismatch count of the current/last sweep (0..8)
//   fail_seen_o   at least one mismatch in the current/last sweep
//   first_fail_o  vector index of the first mismatch, 0 when none
// -----------------------------------------------------------------------------
module equiv_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       s_a_i,
    input  logic       s_b_i,
    output logic       x_o,
    output logic       y_o,
    output logic       z_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_cnt_o,
    output logic       fail_seen_o,
    output logic [2:0] first_fail_o
);

    // Terminal value of the hold counter for one vector.
    localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StCheck,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;
    logic       fail_seen_q, fail_seen_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic       pass_q, pass_d;
    logic       mismatch;

    // The inputs are used only in the CHECK cycle. By then they have had
    // HOLD_CYCLES cycles to settle against the registered vector.
    assign mismatch = s_a_i ^ s_b_i;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        fail_cnt_d   = fail_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d      = StHold;
                    vec_d        = 3'd0;
                    cnt_d        = 4'd0;
                    fail_cnt_d   = 4'd0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = 3'd0;
                    pass_d       = 1'b0;
                end
            end

            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StCheck: begin
                // Eight vectors at most, so the 4-bit count cannot wrap.
                if (mismatch) begin
                    fail_cnt_d = fail_cnt_q + 4'd1;
                    if (!fail_seen_q) begin
                        first_fail_d = vec_q;
                        fail_seen_d  = 1'b1;
                    end
                end

`ifdef EQUIV_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = StDone;
                    pass_d  = 1'b0;
                end else if (vec_q == 3'd7) begin
                    state_d = StDone;
                    pass_d  = (fail_cnt_d == 4'd0);
                end else begin
                    state_d = StHold;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = 4'd0;
                end
`else
                if (vec_q == 3'd7) begin
                    state_d = StDone;
                    // Use the count that includes this final check. Setting
                    // the flag on entry makes pass_o valid alongside done_o.
                    pass_d  = (fail_cnt_d == 4'd0);
                end else begin
                    state_d = StHold;
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = 4'd0;
                end
`endif
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            vec_q        <= 3'd0;
            cnt_q        <= 4'd0;
            fail_cnt_q   <= 4'd0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 3'd0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    // The outputs are decoded straight from the state register, so done_o
    // and busy_o are mutually exclusive by construction.
    assign x_o          = vec_q[0];
    assign y_o          = vec_q[1];
    assign z_o          = vec_q[2];
    assign busy_o       = (state_q == StHold) || (state_q == StCheck);
    assign done_o       = (state_q == StDone);
    assign pass_o       = pass_q;
    assign fail_cnt_o   = fail_cnt_q;
    assign fail_seen_o  = fail_seen_q;
    assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_equiv_sweep_ctrl
//
// The bench drives two instances, one with HOLD_CYCLES=4 and one with
// HOLD_CYCLES=1. The law implementations are modelled in the bench.
// Implementation A is (x&y)|z, or plain x in the "ux" mode. Implementation B
// is A XOR a per-vector corruption mask, or constant 0 in the "ux" mode.
// Expected results come from fixed table constants, or from a sweep model
// that evaluates both laws over all eight vectors.
// -----------------------------------------------------------------------------
module tb_equiv_sweep_ctrl;

    localparam int H0 = 4;
    localparam int H1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      start;
    logic [1:0]      sa, sb;
    logic [1:0]      xw, yw, zw, busyw, donew, passw, fsw;
    logic [1:0][3:0] fcw;
    logic [1:0][2:0] ffw;
    logic [1:0][7:0] mask_r;
    logic [1:0]      ux_r;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int   lat;
        int   cnt;
        int   ff;
        logic pass;
        int   vec;
    } res_t;

    typedef struct {
        int         d;
        logic [7:0] m;
        logic       ux;
        int         lat;
        int         cnt;
        int         ff;
        logic       pass;
        int         vec;
    } tv_t;

    function automatic logic law_a(logic [2:0] v, logic ux);
        return ux ? v[0] : ((v[0] & v[1]) | v[2]);
    endfunction

    function automatic logic law_b(logic [2:0] v, logic ux, logic [7:0] m);
        return ux ? 1'b0 : (law_a(v, 1'b0) ^ m[v]);
    endfunction

    assign sa[0] = law_a({zw[0], yw[0], xw[0]}, ux_r[0]);
    assign sb[0] = law_b({zw[0], yw[0], xw[0]}, ux_r[0], mask_r[0]);
    assign sa[1] = law_a({zw[1], yw[1], xw[1]}, ux_r[1]);
    assign sb[1] = law_b({zw[1], yw[1], xw[1]}, ux_r[1], mask_r[1]);

    equiv_sweep_ctrl #(.HOLD_CYCLES(H0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start[0]),
        .s_a_i       (sa[0]),
        .s_b_i       (sb[0]),
        .x_o         (xw[0]),
        .y_o         (yw[0]),
        .z_o         (zw[0]),
        .busy_o      (busyw[0]),
        .done_o      (donew[0]),
        .pass_o      (passw[0]),
        .fail_cnt_o  (fcw[0]),
        .fail_seen_o (fsw[0]),
        .first_fail_o(ffw[0])
    );

    equiv_sweep_ctrl #(.HOLD_CYCLES(H1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start[1]),
        .s_a_i       (sa[1]),
        .s_b_i       (sb[1]),
        .x_o         (xw[1]),
        .y_o         (yw[1]),
        .z_o         (zw[1]),
        .busy_o      (busyw[1]),
        .done_o      (donew[1]),
        .pass_o      (passw[1]),
        .fail_cnt_o  (fcw[1]),
        .fail_seen_o (fsw[1]),
        .first_fail_o(ffw[1])
    );

    // Sweep model: evaluate both laws over every vector. The sweep ends after
    // vector 7, or after the first mismatch when stop-on-fail is enabled.
    function automatic res_t model(logic [7:0] m, logic ux, int h);
        res_t r;
        int   k;
        bit   stopped;
        r.cnt   = 0;
        r.ff    = 0;
        r.vec   = 7;
        k       = 8;
        stopped = 0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            if (!stopped && (law_a(vv, ux) != law_b(vv, ux, m))) begin
                if (r.cnt == 0) r.ff = v;
                r.cnt++;
`ifdef EQUIV_STOP_ON_FAIL_EN
                stopped = 1;
                k       = v + 1;
                r.vec   = v;
`endif
            end
        end
        r.lat  = k * (h + 1);
        r.pass = (r.cnt == 0);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int vec_of(int d);
        return int'({zw[d], yw[d], xw[d]});
    endfunction

    task automatic chk_zero(input int d);
        chk("rst vec", vec_of(d), 0);
        chk("rst busy", int'(busyw[d]), 0);
        chk("rst done", int'(donew[d]), 0);
        chk("rst pass", int'(passw[d]), 0);
        chk("rst fail_cnt", int'(fcw[d]), 0);
        chk("rst fail_seen", int'(fsw[d]), 0);
        chk("rst first_fail", int'(ffw[d]), 0);
    endtask

    // Run this at the negedge right after the edge that accepted start.
    task automatic chk_started(input int d);
        chk("start busy", int'(busyw[d]), 1);
        chk("start done", int'(donew[d]), 0);
        chk("start vec", vec_of(d), 0);
        chk("start fail_cnt", int'(fcw[d]), 0);
        chk("start fail_seen", int'(fsw[d]), 0);
        chk("start first_fail", int'(ffw[d]), 0);
        chk("start pass", int'(passw[d]), 0);
    endtask

    task automatic launch(input int d, input logic [7:0] m, input logic ux, input bit keep);
        @(negedge clk);
        mask_r[d] = m;
        ux_r[d]   = ux;
        start[d]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) start[d] = 1'b0;
        chk_started(d);
    endtask

    // Count the edges after the start edge until done_o appears, then check
    // the report. One cycle later, check pass_o and the end of the pulse.
    task automatic finish(input int d, input bit poke, input res_t e);
        int n;
        n = 0;
        while (n < 400 && !donew[d]) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (poke && n == 1) start[d] = 1'b1;
            if (poke && n == 2) start[d] = 1'b0;
        end
        chk("done latency", n, e.lat);
        chk("done busy", int'(busyw[d]), 0);
        chk("fail_cnt", int'(fcw[d]), e.cnt);
        chk("fail_seen", int'(fsw[d]), int'(e.cnt != 0));
        chk("first_fail", int'(ffw[d]), e.ff);
        chk("final vec", vec_of(d), e.vec);
        @(negedge clk);
        chk("done pulse width", int'(donew[d]), 0);
        chk("pass", int'(passw[d]), int'(e.pass));
    endtask

    tv_t  tbl[5];
    res_t e;

    initial begin
        tbl[0] = '{0, 8'h00, 1'b0, 40, 0, 0, 1'b1, 7};
        tbl[3] = '{1, 8'h00, 1'b0, 16, 0, 0, 1'b1, 7};
`ifdef EQUIV_STOP_ON_FAIL_EN
        tbl[1] = '{0, 8'h20, 1'b0, 30, 1, 5, 1'b0, 5};
        tbl[2] = '{0, 8'h00, 1'b1, 10, 1, 1, 1'b0, 1};
        tbl[4] = '{1, 8'h81, 1'b0, 2, 1, 0, 1'b0, 0};
`else
        tbl[1] = '{0, 8'h20, 1'b0, 40, 1, 5, 1'b0, 7};
        tbl[2] = '{0, 8'h00, 1'b1, 40, 4, 1, 1'b0, 7};
        tbl[4] = '{1, 8'h81, 1'b0, 16, 2, 0, 1'b0, 7};
`endif

        rst    = 1'b1;
        start  = 2'b00;
        mask_r = '0;
        ux_r   = 2'b00;
        #12;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors from the table.
        for (int i = 0; i < 5; i++) begin
            e.lat  = tbl[i].lat;
            e.cnt  = tbl[i].cnt;
            e.ff   = tbl[i].ff;
            e.pass = tbl[i].pass;
            e.vec  = tbl[i].vec;
            launch(tbl[i].d, tbl[i].m, tbl[i].ux, 1'b0);
            finish(tbl[i].d, 1'b0, e);
        end

        // A start pulse while busy must be ignored.
        launch(0, 8'h00, 1'b0, 1'b0);
        finish(0, 1'b1, model(8'h00, 1'b0, H0));

        // Start held high: the sweep restarts right after the done cycle,
        // with the report cleared.
        launch(0, 8'h20, 1'b0, 1'b1);
        finish(0, 1'b0, model(8'h20, 1'b0, H0));
        @(posedge clk);
        @(negedge clk);
        start[0]  = 1'b0;
        mask_r[0] = 8'h00;
        chk_started(0);
        finish(0, 1'b0, model(8'h00, 1'b0, H0));

        // Asynchronous reset in the middle of the HOLD phase of vector 3.
        launch(0, 8'h06, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #1;
`ifdef EQUIV_STOP_ON_FAIL_EN
        chk("pre-rst busy", int'(busyw[0]), 0);
`else
        chk("pre-rst vec", vec_of(0), 3);
        chk("pre-rst fail_cnt", int'(fcw[0]), 2);
`endif
        #1 rst = 1'b1;
        #1;
        chk_zero(0);
        @(negedge clk);
        rst = 1'b0;
        launch(0, 8'h06, 1'b0, 1'b0);
        finish(0, 1'b0, model(8'h06, 1'b0, H0));

        // Random laws on both instances, checked against the sweep model.
        for (int i = 0; i < 12; i++) begin
            int         d;
            logic [7:0] m;
            logic       ux;
            bit         poke;
            d    = int'($urandom_range(0, 1));
            m    = 8'($urandom);
            if ($urandom_range(0, 3) == 0) m = 8'h00;
            ux   = ($urandom_range(0, 4) == 0);
            poke = ($urandom_range(0, 1) == 1);
            launch(d, m, ux, 1'b0);
            finish(d, poke, model(m, ux, (d == 0) ? H0 : H1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
